// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial nibble transmitter.
// Also provides the counter-width helper used to size the bit-period counter.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  // A counter for n states never gets narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button, with a one-cycle
// rising-edge pulse derived from the synchronized level.
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic sync_o,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/serial_tx_nibble.sv
// Push-button triggered serial transmitter: start bit, DATA_BITS data bits
// LSB first, stop bit, each held CLKS_PER_BIT cycles. Outputs are registered.
module serial_tx_nibble
  import serial_tx_pkg::*;
#(
  parameter int DATA_BITS    = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 input_clock1_clk_1,
  input  logic                 input_input_switch2__clear_2,
  input  logic                 input_push_button3_start_3,
  input  logic [DATA_BITS-1:0] input_input_switch4_data_4,
  output logic                 output_led1_tx_5,
  output logic                 output_led2_busy_6,
  output logic                 output_led3_done_7
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic clk;
  logic rst_n;
  logic start_rise;
  logic btn_level_unused;

  assign clk   = input_clock1_clk_1;
  assign rst_n = input_input_switch2__clear_2;

  button_sync_edge u_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (input_push_button3_start_3),
    .sync_o (btn_level_unused),
    .rise_o (start_rise)
  );

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cyc_q,   cyc_d;
  logic [BW-1:0]        bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q,    tx_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic                 cyc_last;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    cyc_last = (cyc_q == CYC_LAST);

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          shift_d = input_input_switch4_data_4;
          bit_d   = '0;
          cyc_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_last) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STOP: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = STOP_BIT;
      default: tx_d = TX_IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= TX_IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign output_led1_tx_5   = tx_q;
  assign output_led2_busy_6 = busy_q;
  assign output_led3_done_7 = done_q;

endmodule
